ecc_decode_pipe: RTL and testbench

- Pipelined multi-width SECDED Hamming decoder: successor to the combinational syndrome block.
- Supports 8/16/32-bit codewords, selected per word.
- Computes the syndrome, classifies the error, corrects single-bit errors and counts error events.
- Sits between the noisy-channel receiver and the data consumer, with valid/ready handshakes on both sides.

---
 rtl/ecc_decode_pipe.sv | 245 ++++++++++++++++++++++++
 tb/tb_ecc_decode_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_decode_pipe.sv
// Two-stage SECDED decoder for 8/16/32-bit codewords with valid/ready on both sides.
// Define ECC_ERR_CNT_EN to build the saturating corrected/uncorrected counters.
module ecc_decode_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] NoisyCodeWord,
    input  logic [1:0]            Codeword_Width,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] CorrectedWord,
    output logic [5:0]            syndrome,
    output logic [1:0]            err_status,
    output logic [4:0]            err_pos,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  corr_cnt,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt
);

    typedef enum logic [1:0] {
        M8  = 2'd0,
        M16 = 2'd1,
        M32 = 2'd2
    } mode_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] word;
        logic [4:0]            s;
        logic                  p;
        mode_e                 mode;
    } s1_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] word;
        logic [5:0]            syn;
        logic [1:0]            status;
        logic [4:0]            pos;
    } s2_t;

    // Check bits use powers of two; data bits take the remaining codes in order.
    function automatic logic [4:0] col_code(input int idx, input int r);
        int          cnt;
        logic [4:0]  code;
        code = '0;
        cnt  = r;
        if (idx < r) begin
            code = 5'(1 << idx);
        end else if (idx > r) begin
            for (int c = 3; c < 32; c++) begin
                if ((c & (c - 1)) != 0) begin
                    cnt++;
                    if (cnt == idx) code = 5'(c);
                end
            end
        end
        return code;
    endfunction

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    logic s1_valid, s2_valid;
    logic stall;

    mode_e                 in_mode;
    int                    width;
    logic [DATA_WIDTH-1:0] mask;
    logic [4:0]            s8, s16, s32;

    always_comb begin
        unique case (1'b1)
            Codeword_Width == 2'd0: in_mode = M8;
            Codeword_Width == 2'd1: in_mode = M16;
            default:                in_mode = (DATA_WIDTH > 16) ? M32 : M16;
        endcase
    end

    always_comb begin
        width = 32;
        unique case (in_mode)
            M8:      width = 8;
            M16:     width = 16;
            default: width = 32;
        endcase
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = (i < width);
        end
    end

    always_comb begin
        s8  = '0;
        s16 = '0;
        s32 = '0;
        for (int i = 0; i < 8; i++) begin
            if (NoisyCodeWord[i]) s8 = s8 ^ col_code(i, 3);
        end
        for (int i = 0; i < 16; i++) begin
            if (NoisyCodeWord[i]) s16 = s16 ^ col_code(i, 4);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (NoisyCodeWord[i]) s32 = s32 ^ col_code(i, 5);
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.word = NoisyCodeWord & mask;
        s1_d.p    = ^(NoisyCodeWord & mask);
        s1_d.mode = in_mode;
        unique case (in_mode)
            M8:      s1_d.s = s8;
            M16:     s1_d.s = s16;
            default: s1_d.s = s32;
        endcase
    end

    logic [2:0] r;
    logic [2:0] lg;
    logic       pow2;
    logic [4:0] pos_c;

    always_comb begin
        r = 3'd5;
        s2_d = '0;
        unique case (s1_q.mode)
            M8: begin
                r = 3'd3;
                s2_d.syn = {2'b0, s1_q.p, s1_q.s[2:0]};
            end
            M16: begin
                r = 3'd4;
                s2_d.syn = {1'b0, s1_q.p, s1_q.s[3:0]};
            end
            default: begin
                r = 3'd5;
                s2_d.syn = {s1_q.p, s1_q.s};
            end
        endcase
    end

    always_comb begin
        lg = '0;
        for (int k = 0; k < 5; k++) begin
            if (s1_q.s[k]) lg = 3'(k);
        end
        pow2 = (s1_q.s != 5'd0) && ((s1_q.s & (s1_q.s - 5'd1)) == 5'd0);
        // Modular 5-bit arithmetic: the true position always fits.
        unique case (1'b1)
            s1_q.s == 5'd0: pos_c = 5'(r);
            pow2:           pos_c = {2'b0, lg};
            default:        pos_c = 5'(r) + s1_q.s - 5'd1 - 5'(lg);
        endcase
    end

    logic [DATA_WIDTH-1:0] flipped;
    assign flipped = s1_q.word ^ (DATA_WIDTH'(1'b1) << pos_c);

    logic [DATA_WIDTH-1:0] word_c;
    logic [1:0]            status_c;
    logic [4:0]            pos_o;

    always_comb begin
        word_c   = s1_q.word;
        status_c = 2'b00;
        pos_o    = '0;
        unique case (1'b1)
            !s1_q.p && s1_q.s == 5'd0: status_c = 2'b00;
            s1_q.p: begin
                status_c = 2'b01;
                pos_o    = pos_c;
                word_c   = flipped;
            end
            default: status_c = 2'b10;
        endcase
    end

    s2_t s2_n;
    always_comb begin
        s2_n        = s2_d;
        s2_n.word   = word_c;
        s2_n.status = status_c;
        s2_n.pos    = pos_o;
    end

    assign stall    = s2_valid && !out_ready;
    assign in_ready = !stall || !s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_q <= s2_n;
        end
    end

    assign out_valid     = s2_valid;
    assign CorrectedWord = s2_q.word;
    assign syndrome      = s2_q.syn;
    assign err_status    = s2_q.status;
    assign err_pos       = s2_q.pos;

`ifdef ECC_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] corr_q, uncorr_q;
    logic                 xfer;
    assign xfer = out_valid && out_ready;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (xfer) begin
            if (s2_q.status == 2'b01 && corr_q != '1)
                corr_q <= corr_q + 1'b1;
            if (s2_q.status == 2'b10 && uncorr_q != '1)
                uncorr_q <= uncorr_q + 1'b1;
        end
    end

    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Bench for ecc_decode_pipe: a 32-bit/16-bit-counter instance and a
// 16-bit/2-bit-counter instance share stimulus; a reference model scores both.
module tb_ecc_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, cnt_clr;
    logic [31:0] word;
    logic [1:0]  cw;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_cw;
    logic [5:0]  a_syn;
    logic [1:0]  a_st;
    logic [4:0]  a_pos;
    logic [15:0] a_corr, a_unc;

    logic        b_in_ready, b_out_valid;
    logic [15:0] b_cw;
    logic [5:0]  b_syn;
    logic [1:0]  b_st;
    logic [4:0]  b_pos;
    logic [1:0]  b_corr, b_unc;

    always #5 clk = ~clk;

    ecc_decode_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .NoisyCodeWord(word), .Codeword_Width(cw),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .CorrectedWord(a_cw), .syndrome(a_syn), .err_status(a_st),
        .err_pos(a_pos), .cnt_clr(cnt_clr),
        .corr_cnt(a_corr), .uncorr_cnt(a_unc)
    );

    ecc_decode_pipe #(.DATA_WIDTH(16), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .NoisyCodeWord(word[15:0]), .Codeword_Width(cw),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .CorrectedWord(b_cw), .syndrome(b_syn), .err_status(b_st),
        .err_pos(b_pos), .cnt_clr(cnt_clr),
        .corr_cnt(b_corr), .uncorr_cnt(b_unc)
    );

    typedef struct {
        logic [31:0] cw;
        logic [5:0]  syn;
        logic [1:0]  st;
        logic [4:0]  pos;
    } exp_t;

    typedef struct {
        exp_t a;
        exp_t b;
        int   acc;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ndel = 0;
    int   ma_corr = 0, ma_unc = 0, mb_corr = 0, mb_unc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ecnt(input int v);
`ifdef ECC_ERR_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    // Reference decode: build the H columns, XOR them, then search for the column.
    function automatic exp_t decode(input logic [31:0] w, input logic [1:0] mode,
                                    input int dw);
        exp_t        e;
        int          n, r, c, s, j;
        int          col[32];
        logic [31:0] m;
        bit          p;
        n = (mode == 2'd0) ? 8 : (mode == 2'd1 || dw == 16) ? 16 : 32;
        r = (n == 8) ? 3 : (n == 16) ? 4 : 5;
        c = 3;
        for (int i = 0; i < 32; i++) col[i] = 0;
        for (int i = 0; i < n; i++) begin
            if (i < r) begin
                col[i] = 1 << i;
            end else if (i > r) begin
                while ($countones(c) == 1) c++;
                col[i] = c;
                c++;
            end
        end
        m = '0;
        s = 0;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (w[i]) begin
                m[i] = 1'b1;
                s = s ^ col[i];
                p = !p;
            end
        end
        e.syn = 6'(s | (int'(p) << r));
        e.cw  = m;
        e.st  = 2'd0;
        e.pos = 5'd0;
        if (p) begin
            e.st = 2'd1;
            j = -1;
            if (s == 0) j = r;
            else begin
                for (int i = 0; i < n; i++) begin
                    if (i != r && col[i] == s) j = i;
                end
            end
            if (j >= 0) begin
                e.pos  = 5'(j);
                e.cw[j] = !m[j];
            end
        end else if (s != 0) begin
            e.st = 2'd2;
        end
        return e;
    endfunction

    initial begin
        bit   exp_ov, exp_ir;
        ent_t ent;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                ma_corr = 0;
                ma_unc  = 0;
                mb_corr = 0;
                mb_unc  = 0;
            end else begin
                exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
                exp_ir = !(exp_ov && !out_ready) || (q.size() < 2);
                chk("a_out_valid", a_out_valid, exp_ov);
                chk("b_out_valid", b_out_valid, exp_ov);
                chk("a_in_ready", a_in_ready, exp_ir);
                chk("b_in_ready", b_in_ready, exp_ir);
                chk("a_corr_cnt", a_corr, ecnt(ma_corr));
                chk("a_uncorr_cnt", a_unc, ecnt(ma_unc));
                chk("b_corr_cnt", b_corr, ecnt(mb_corr));
                chk("b_uncorr_cnt", b_unc, ecnt(mb_unc));
                if (exp_ov && a_out_valid) begin
                    chk("a_word", a_cw, q[0].a.cw);
                    chk("a_syndrome", a_syn, q[0].a.syn);
                    chk("a_status", a_st, q[0].a.st);
                    chk("a_pos", a_pos, q[0].a.pos);
                    chk("b_word", b_cw, q[0].b.cw);
                    chk("b_syndrome", b_syn, q[0].b.syn);
                    chk("b_status", b_st, q[0].b.st);
                    chk("b_pos", b_pos, q[0].b.pos);
                end
                if (exp_ov && out_ready) begin
                    if (q[0].a.st == 2'd1) ma_corr = sat(ma_corr, 65535);
                    if (q[0].a.st == 2'd2) ma_unc  = sat(ma_unc, 65535);
                    if (q[0].b.st == 2'd1) mb_corr = sat(mb_corr, 3);
                    if (q[0].b.st == 2'd2) mb_unc  = sat(mb_unc, 3);
                    void'(q.pop_front());
                    ndel++;
                end
                if (cnt_clr) begin
                    ma_corr = 0;
                    ma_unc  = 0;
                    mb_corr = 0;
                    mb_unc  = 0;
                end
                if (in_valid && exp_ir) begin
                    ent.a   = decode(word, cw, 32);
                    ent.b   = decode({16'h0, word[15:0]}, cw, 16);
                    ent.acc = cyc;
                    q.push_back(ent);
                end
            end
            cyc++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] m);
        int n;
        in_valid = 1'b1;
        word     = w;
        cw       = m;
        n        = 0;
        @(negedge clk);
        while (!a_in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", a_in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain", q.size(), 0);
        sync();
    endtask

    task automatic dcheck(input string nm, input logic [31:0] w,
                          input logic [1:0] m, input logic [5:0] syn,
                          input logic [1:0] st, input logic [4:0] pos,
                          input logic [31:0] cwv);
        send(w, m);
        @(negedge clk);
        chk({nm, "_early"}, a_out_valid, 1'b0);
        @(negedge clk);
        chk({nm, "_valid"}, a_out_valid, 1'b1);
        chk({nm, "_syn"}, a_syn, syn);
        chk({nm, "_status"}, a_st, st);
        chk({nm, "_pos"}, a_pos, pos);
        chk({nm, "_word"}, a_cw, cwv);
        sync();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] tw[6];
        logic [1:0]  tm[6];
        exp_t        e;
        bit          saw_drop;
        int          nd0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        word      = '0;
        cw        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_word", a_cw, 32'h0);
        chk("rst_syn", a_syn, 6'h0);
        chk("rst_status", a_st, 2'd0);
        chk("rst_pos", a_pos, 5'd0);
        chk("rst_corr", a_corr, 16'd0);
        chk("rst_b_valid", b_out_valid, 1'b0);

        e = decode(32'h40, 2'd0, 32);
        chk("model_8b", {e.syn, e.st, e.pos, e.cw}, {6'h0E, 2'd1, 5'd6, 32'h0});
        e = decode(32'h3, 2'd1, 32);
        chk("model_16d", {e.syn, e.st, e.cw}, {6'h03, 2'd2, 32'h3});
        e = decode(32'h8000_0000, 2'd2, 32);
        chk("model_32m", {e.syn, e.pos, e.cw}, {6'h3F, 5'd31, 32'h0});
        e = decode(32'h20, 2'd2, 32);
        chk("model_32p", {e.syn, e.pos}, {6'h20, 5'd5});
        e = decode(32'h8000, 2'd3, 16);
        chk("model_clamp", {e.syn, e.pos}, {6'h1F, 5'd15});
        sync();

        dcheck("clean8", 32'h0, 2'd0, 6'h00, 2'd0, 5'd0, 32'h0);
        dcheck("single8", 32'h40, 2'd0, 6'h0E, 2'd1, 5'd6, 32'h0);
        @(negedge clk);
        chk("corr_cnt_one", a_corr, ecnt(1));
        sync();
        dcheck("double16", 32'h3, 2'd1, 6'h03, 2'd2, 5'd0, 32'h3);
        @(negedge clk);
        chk("uncorr_cnt_one", a_unc, ecnt(1));
        sync();
        dcheck("msb32", 32'h8000_0000, 2'd2, 6'h3F, 2'd1, 5'd31, 32'h0);
        dcheck("par32", 32'h20, 2'd2, 6'h20, 2'd1, 5'd5, 32'h0);

        send(32'h8000, 2'd3);
        @(negedge clk);
        @(negedge clk);
        chk("clamp_b_syn", b_syn, 6'h1F);
        chk("clamp_b_pos", b_pos, 5'd15);
        chk("clamp_a_syn", a_syn, 6'h2E);
        sync();

        tw = '{32'h0000_00F0, 32'h0000_0101, 32'hFFFF_FFFF,
               32'h1234_5678, 32'h0000_0007, 32'hA5A5_0000};
        tm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 6; i++) send(tw[i], tm[i]);
        drain();

        nd0      = ndel;
        saw_drop = 1'b0;
        fork
            begin
                send(32'h40, 2'd0);
                send(32'h3, 2'd1);
                send(32'h8000_0000, 2'd2);
                send(32'h0000_0024, 2'd3);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!a_in_ready) saw_drop = 1'b1;
                end
            end
        join
        drain();
        chk("bp_in_ready_drop", saw_drop, 1'b1);
        chk("bp_delivered", ndel - nd0, 4);

        send(32'h40, 2'd0);
        send(32'h40, 2'd0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_a_valid", a_out_valid, 1'b0);
        chk("midrst_b_valid", b_out_valid, 1'b0);
        chk("midrst_a_corr", a_corr, 16'd0);
        chk("midrst_b_corr", b_corr, 2'd0);
        chk("midrst_a_unc", a_unc, 16'd0);
        sync();

        repeat (5) send(32'h40, 2'd0);
        drain();
        @(negedge clk);
        chk("sat_a_corr", a_corr, ecnt(5));
        chk("sat_b_corr", b_corr, ecnt(3));
        sync();

        send(32'h40, 2'd0);
        sync();
        cnt_clr = 1'b1;
        sync();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_a_corr", a_corr, 16'd0);
        chk("clr_b_corr", b_corr, 2'd0);
        chk("clr_empty", q.size(), 0);
        sync();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
